// File: rtl/k_in_row_game_pkg.sv
// Shared encodings for the k-in-a-row game: cell values, FSM states and
// scan directions.
package k_in_row_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b01;
    localparam logic [1:0] CELL_O     = 2'b10;

    typedef enum logic [2:0] {
        S_INI,
        S_STA,
        S_TURN,
        S_CHECK,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        DIR_H,
        DIR_V,
        DIR_D,
        DIR_A
    } dir_t;

    function automatic logic [1:0] mark_of(input logic player);
        return player ? CELL_O : CELL_X;
    endfunction

    function automatic dir_t next_dir(input dir_t d);
        case (d)
            DIR_H:   return DIR_V;
            DIR_V:   return DIR_D;
            DIR_D:   return DIR_A;
            default: return DIR_H;
        endcase
    endfunction

endpackage

// File: rtl/k_in_row_game_if.sv
// Player-facing bus of the game: buttons in, state/cursor/score/display out.
interface k_in_row_game_if #(
    parameter int N       = 3,
    parameter int SCORE_W = 12
);
    localparam int W = $clog2(N);

    logic               Start;
    logic               Ack;
    logic               BtnU;
    logic               BtnD;
    logic               BtnL;
    logic               BtnR;
    logic               BtnC;
    logic               Qi;
    logic               Qs;
    logic               Qt;
    logic               Qc;
    logic               Qd;
    logic [W-1:0]       CurRow;
    logic [W-1:0]       CurCol;
    logic               Player;
    logic [W-1:0]       RdRow;
    logic [W-1:0]       RdCol;
    logic [1:0]         RdCell;
    logic               Xwins;
    logic               Owins;
    logic               Draw;
    logic [SCORE_W-1:0] P1s;
    logic [SCORE_W-1:0] P2s;

    modport master (
        output Start, Ack, BtnU, BtnD, BtnL, BtnR, BtnC, RdRow, RdCol,
        input  Qi, Qs, Qt, Qc, Qd, CurRow, CurCol, Player, RdCell,
               Xwins, Owins, Draw, P1s, P2s
    );

    modport slave (
        input  Start, Ack, BtnU, BtnD, BtnL, BtnR, BtnC, RdRow, RdCol,
        output Qi, Qs, Qt, Qc, Qd, CurRow, CurCol, Player, RdCell,
               Xwins, Owins, Draw, P1s, P2s
    );

endinterface

// File: rtl/k_in_row_game_scan.sv
// Line scanner: from the last placed cell, walks each direction one probe per
// cycle and reports done/win combinationally in the deciding cycle.
module k_in_row_scan
    import k_in_row_pkg::*;
#(
    parameter int N = 3,
    parameter int K = 3
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 start,
    input  logic [$clog2(N)-1:0] prow,
    input  logic [$clog2(N)-1:0] pcol,
    input  logic [1:0]           mark,
    output logic [$clog2(N)-1:0] probeRow,
    output logic [$clog2(N)-1:0] probeCol,
    input  logic [1:0]           probeCell,
    output logic                 done,
    output logic                 win
);

    localparam int W  = $clog2(N);
    localparam int SW = $clog2(K) + 1;
    localparam logic [SW-1:0] STEP_MAX = SW'(K - 1);

    logic          busy;
    dir_t          dir;
    logic          side;
    logic [SW-1:0] step;
    logic [SW-1:0] cnt;
    logic [W-1:0]  rowQ;
    logic [W-1:0]  colQ;
    logic [1:0]    markQ;

    int   dr;
    int   dc;
    int   r;
    int   c;
    logic onBoard;
    logic hit;
    logic winNow;

    // Candidate cell = placed cell + step * (signed direction vector); an
    // off-board candidate ends the side just like a non-matching cell.
    always_comb begin
        dr = 0;
        dc = 1;
        case (dir)
            DIR_H:   begin dr = 0; dc = 1;  end
            DIR_V:   begin dr = 1; dc = 0;  end
            DIR_D:   begin dr = 1; dc = 1;  end
            default: begin dr = 1; dc = -1; end
        endcase
        if (side) begin
            dr = -dr;
            dc = -dc;
        end
        r       = int'(rowQ) + dr * int'(step);
        c       = int'(colQ) + dc * int'(step);
        onBoard = (r >= 0) && (r < N) && (c >= 0) && (c < N);
        probeRow = onBoard ? r[W-1:0] : '0;
        probeCol = onBoard ? c[W-1:0] : '0;
        hit      = busy && onBoard && (probeCell == markQ);
        winNow   = hit && ((int'(cnt) + 2) >= K);
        win      = winNow;
        done     = busy && (winNow ||
                   ((dir == DIR_A) && side && (!hit || step == STEP_MAX)));
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            busy  <= 1'b0;
            dir   <= DIR_H;
            side  <= 1'b0;
            step  <= '0;
            cnt   <= '0;
            rowQ  <= '0;
            colQ  <= '0;
            markQ <= CELL_EMPTY;
        end else if (start) begin
            busy  <= 1'b1;
            dir   <= DIR_H;
            side  <= 1'b0;
            step  <= SW'(1);
            cnt   <= '0;
            rowQ  <= prow;
            colQ  <= pcol;
            markQ <= mark;
        end else if (busy) begin
            if (done) begin
                busy <= 1'b0;
            end else if (hit && step != STEP_MAX) begin
                step <= step + 1'b1;
                cnt  <= cnt + 1'b1;
            end else begin
                // Side exhausted: flip to the minus side, or move on to the
                // next direction with a fresh match count.
                step <= SW'(1);
                if (!side) begin
                    side <= 1'b1;
                    if (hit) cnt <= cnt + 1'b1;
                end else begin
                    side <= 1'b0;
                    cnt  <= '0;
                    dir  <= next_dir(dir);
                end
            end
        end
    end

endmodule

// File: rtl/k_in_row_game.sv
// N x N k-in-a-row game: turn FSM, flop board, cursor, scoring; win detection
// is delegated to k_in_row_scan.
module k_in_row_game
    import k_in_row_pkg::*;
#(
    parameter int N       = 3,
    parameter int K       = 3,
    parameter int SCORE_W = 12
) (
    input  logic          Clk,
    input  logic          Reset,
    k_in_row_game_if.slave bus
);

    localparam int W     = $clog2(N);
    localparam int CELLS = N * N;
    localparam int MW    = $clog2(CELLS + 1);
    localparam logic [W-1:0] LAST = W'(N - 1);

    state_t             state;
    logic [1:0]         board [N][N];
    logic [W-1:0]       curRow;
    logic [W-1:0]       curCol;
    logic               player;
    logic               nextFirst;
    logic               xwins;
    logic               owins;
    logic               draw;
    logic [MW-1:0]      moveCnt;
    logic [SCORE_W-1:0] p1s;
    logic [SCORE_W-1:0] p2s;

    logic [W-1:0] probeRow;
    logic [W-1:0] probeCol;
    logic [1:0]   probeCell;
    logic [1:0]   curCell;
    logic [1:0]   curMark;
    logic         scanStart;
    logic         scanDone;
    logic         scanWin;

    assign curCell   = board[curRow][curCol];
    assign probeCell = board[probeRow][probeCol];
    assign curMark   = mark_of(player);
    assign scanStart = (state == S_TURN) && bus.BtnC && (curCell == CELL_EMPTY);

    assign bus.RdCell = ((int'(bus.RdRow) < N) && (int'(bus.RdCol) < N)) ?
                        board[bus.RdRow][bus.RdCol] : CELL_EMPTY;

    k_in_row_scan #(.N(N), .K(K)) u_scan (
        .Clk       (Clk),
        .Reset     (Reset),
        .start     (scanStart),
        .prow      (curRow),
        .pcol      (curCol),
        .mark      (curMark),
        .probeRow  (probeRow),
        .probeCol  (probeCol),
        .probeCell (probeCell),
        .done      (scanDone),
        .win       (scanWin)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= S_INI;
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    board[r][c] <= CELL_EMPTY;
            curRow    <= '0;
            curCol    <= '0;
            player    <= 1'b0;
            nextFirst <= 1'b0;
            moveCnt   <= '0;
            xwins     <= 1'b0;
            owins     <= 1'b0;
            draw      <= 1'b0;
            p1s       <= '0;
            p2s       <= '0;
        end else begin
            case (state)
                S_INI: begin
                    p1s       <= '0;
                    p2s       <= '0;
                    nextFirst <= 1'b0;
                    if (bus.Start) state <= S_STA;
                end
                S_STA: begin
                    for (int r = 0; r < N; r++)
                        for (int c = 0; c < N; c++)
                            board[r][c] <= CELL_EMPTY;
                    curRow  <= '0;
                    curCol  <= '0;
                    moveCnt <= '0;
                    xwins   <= 1'b0;
                    owins   <= 1'b0;
                    draw    <= 1'b0;
                    player  <= nextFirst;
                    state   <= S_TURN;
                end
                S_TURN: begin
                    // A centre press masks every move button in the same cycle.
                    if (bus.BtnC) begin
                        if (curCell == CELL_EMPTY) begin
                            board[curRow][curCol] <= curMark;
                            moveCnt <= moveCnt + 1'b1;
                            state   <= S_CHECK;
                        end
                    end else if (bus.BtnU) begin
                        curRow <= (curRow == '0) ? LAST : curRow - 1'b1;
                    end else if (bus.BtnD) begin
                        curRow <= (curRow == LAST) ? '0 : curRow + 1'b1;
                    end else if (bus.BtnL) begin
                        curCol <= (curCol == '0) ? LAST : curCol - 1'b1;
                    end else if (bus.BtnR) begin
                        curCol <= (curCol == LAST) ? '0 : curCol + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (scanDone) begin
                        if (scanWin) begin
                            if (!player) begin
                                xwins <= 1'b1;
                                if (p1s != '1) p1s <= p1s + 1'b1;
                            end else begin
                                owins <= 1'b1;
                                if (p2s != '1) p2s <= p2s + 1'b1;
                            end
                            nextFirst <= ~nextFirst;
                            state     <= S_DONE;
                        end else if (moveCnt == MW'(CELLS)) begin
                            draw      <= 1'b1;
                            nextFirst <= ~nextFirst;
                            state     <= S_DONE;
                        end else begin
                            player <= ~player;
                            state  <= S_TURN;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.Ack)       state <= S_INI;
                    else if (bus.BtnC) state <= S_STA;
                end
                default: state <= S_INI;
            endcase
        end
    end

    assign bus.Qi     = (state == S_INI);
    assign bus.Qs     = (state == S_STA);
    assign bus.Qt     = (state == S_TURN);
    assign bus.Qc     = (state == S_CHECK);
    assign bus.Qd     = (state == S_DONE);
    assign bus.CurRow = curRow;
    assign bus.CurCol = curCol;
    assign bus.Player = player;
    assign bus.Xwins  = xwins;
    assign bus.Owins  = owins;
    assign bus.Draw   = draw;
    assign bus.P1s    = p1s;
    assign bus.P2s    = p2s;

endmodule

// File: tb/tb_k_in_row_game.sv
// Directed bench: three instances (3x3/K3, 5x5/K4, 3x3 with 2-bit scores)
// driven through scenario tasks with hand-computed expectations.
module tb_k_in_row_game;
    import k_in_row_pkg::*;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic rst3, rst5, rstS;

    k_in_row_game_if #(.N(3), .SCORE_W(12)) bus3();
    k_in_row_game_if #(.N(5), .SCORE_W(12)) bus5();
    k_in_row_game_if #(.N(3), .SCORE_W(2))  busS();

    k_in_row_game #(.N(3), .K(3), .SCORE_W(12)) dut3 (.Clk(Clk), .Reset(rst3), .bus(bus3));
    k_in_row_game #(.N(5), .K(4), .SCORE_W(12)) dut5 (.Clk(Clk), .Reset(rst5), .bus(bus5));
    k_in_row_game #(.N(3), .K(3), .SCORE_W(2))  dutS (.Clk(Clk), .Reset(rstS), .bus(busS));

    localparam logic [6:0] B_ST = 7'b1000000;
    localparam logic [6:0] B_AK = 7'b0100000;
    localparam logic [6:0] B_U  = 7'b0010000;
    localparam logic [6:0] B_D  = 7'b0001000;
    localparam logic [6:0] B_L  = 7'b0000100;
    localparam logic [6:0] B_R  = 7'b0000010;
    localparam logic [6:0] B_C  = 7'b0000001;

    localparam logic [4:0] Q_INI  = 5'b10000;
    localparam logic [4:0] Q_STA  = 5'b01000;
    localparam logic [4:0] Q_TURN = 5'b00100;
    localparam logic [4:0] Q_CHK  = 5'b00010;
    localparam logic [4:0] Q_DONE = 5'b00001;

    int checks = 0;
    int errors = 0;
    int curR[3];
    int curC[3];
    int mv[$];

    function automatic int nOf(input int sel);
        return (sel == 1) ? 5 : 3;
    endfunction

    task automatic setIn(input int sel, input logic [6:0] v);
        case (sel)
            0: {bus3.Start, bus3.Ack, bus3.BtnU, bus3.BtnD, bus3.BtnL, bus3.BtnR, bus3.BtnC} = v;
            1: {bus5.Start, bus5.Ack, bus5.BtnU, bus5.BtnD, bus5.BtnL, bus5.BtnR, bus5.BtnC} = v;
            default: {busS.Start, busS.Ack, busS.BtnU, busS.BtnD, busS.BtnL, busS.BtnR, busS.BtnC} = v;
        endcase
    endtask

    // One-cycle pulse: driven at a falling edge, consumed by the next rising edge.
    task automatic applyStimulus(input int sel, input logic [6:0] v);
        @(negedge Clk);
        setIn(sel, v);
        @(negedge Clk);
        setIn(sel, 7'b0);
    endtask

    task automatic getStat(input int sel, output logic [4:0] q, output logic pl,
                           output logic [2:0] res, output int p1, output int p2,
                           output int row, output int col);
        case (sel)
            0: begin
                q = {bus3.Qi, bus3.Qs, bus3.Qt, bus3.Qc, bus3.Qd}; pl = bus3.Player;
                res = {bus3.Xwins, bus3.Owins, bus3.Draw};
                p1 = int'(bus3.P1s); p2 = int'(bus3.P2s);
                row = int'(bus3.CurRow); col = int'(bus3.CurCol);
            end
            1: begin
                q = {bus5.Qi, bus5.Qs, bus5.Qt, bus5.Qc, bus5.Qd}; pl = bus5.Player;
                res = {bus5.Xwins, bus5.Owins, bus5.Draw};
                p1 = int'(bus5.P1s); p2 = int'(bus5.P2s);
                row = int'(bus5.CurRow); col = int'(bus5.CurCol);
            end
            default: begin
                q = {busS.Qi, busS.Qs, busS.Qt, busS.Qc, busS.Qd}; pl = busS.Player;
                res = {busS.Xwins, busS.Owins, busS.Draw};
                p1 = int'(busS.P1s); p2 = int'(busS.P2s);
                row = int'(busS.CurRow); col = int'(busS.CurCol);
            end
        endcase
    endtask

    task automatic readCell(input int sel, input int r, input int c, output logic [1:0] v);
        case (sel)
            0: begin bus3.RdRow = 2'(r); bus3.RdCol = 2'(c); #1 v = bus3.RdCell; end
            1: begin bus5.RdRow = 3'(r); bus5.RdCol = 3'(c); #1 v = bus5.RdCell; end
            default: begin busS.RdRow = 2'(r); busS.RdCol = 2'(c); #1 v = busS.RdCell; end
        endcase
    endtask

    function automatic logic qcOf(input int sel);
        case (sel)
            0: return bus3.Qc;
            1: return bus5.Qc;
            default: return busS.Qc;
        endcase
    endfunction

    // Cursor is walked only forward (D/R) from the bench's own position model.
    task automatic place(input int sel, input int r, input int c);
        int n;
        n = nOf(sel);
        for (int i = 0; i < 8 && curC[sel] != c; i++) begin
            applyStimulus(sel, B_R);
            curC[sel] = (curC[sel] + 1) % n;
        end
        for (int i = 0; i < 8 && curR[sel] != r; i++) begin
            applyStimulus(sel, B_D);
            curR[sel] = (curR[sel] + 1) % n;
        end
        applyStimulus(sel, B_C);
    endtask

    task automatic settle(input int sel, output int cycles);
        cycles = 1;
        while (qcOf(sel) && cycles < 100) begin
            @(negedge Clk);
            cycles++;
        end
    endtask

    task automatic playMoves(input int sel, output int lastCyc);
        lastCyc = 0;
        for (int i = 0; i + 1 < mv.size(); i += 2) begin
            place(sel, mv[i], mv[i+1]);
            settle(sel, lastCyc);
        end
    endtask

    task automatic startGame(input int sel, input logic [6:0] how);
        applyStimulus(sel, how);
        @(negedge Clk);
        curR[sel] = 0;
        curC[sel] = 0;
    endtask

    task automatic test_reset();
        logic [4:0] q; logic pl; logic [2:0] res; int p1, p2, row, col; logic [1:0] v;
        getStat(0, q, pl, res, p1, p2, row, col);
        checks++; if (q !== Q_INI) begin errors++; $display("[TB] FAIL reset_state: got %b expected %b", q, Q_INI); end
        checks++; if ({pl, res} !== 4'b0) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 0000", {pl, res}); end
        checks++; if (p1 !== 0 || p2 !== 0) begin errors++; $display("[TB] FAIL reset_scores: got %0d/%0d expected 0/0", p1, p2); end
        checks++; if (row !== 0 || col !== 0) begin errors++; $display("[TB] FAIL reset_cursor: got (%0d,%0d) expected (0,0)", row, col); end
        readCell(0, 1, 1, v);
        checks++; if (v !== CELL_EMPTY) begin errors++; $display("[TB] FAIL reset_cell: got %b expected 00", v); end
        getStat(1, q, pl, res, p1, p2, row, col);
        checks++; if (q !== Q_INI) begin errors++; $display("[TB] FAIL reset_state_n5: got %b expected %b", q, Q_INI); end
    endtask

    task automatic test_xwin();
        logic [4:0] q; logic pl; logic [2:0] res; int p1, p2, row, col, cyc; logic [1:0] v;
        startGame(0, B_ST);
        getStat(0, q, pl, res, p1, p2, row, col);
        checks++; if (q !== Q_TURN || pl !== 1'b0) begin errors++; $display("[TB] FAIL first_turn: got %b/%b expected %b/0", q, pl, Q_TURN); end
        mv = '{0,0, 1,0, 0,1, 1,1};
        playMoves(0, cyc);
        getStat(0, q, pl, res, p1, p2, row, col);
        checks++; if (q !== Q_TURN || pl !== 1'b0) begin errors++; $display("[TB] FAIL midgame_turn: got %b/%b expected %b/0", q, pl, Q_TURN); end
        mv = '{0,2};
        playMoves(0, cyc);
        getStat(0, q, pl, res, p1, p2, row, col);
        checks++; if (q !== Q_DONE) begin errors++; $display("[TB] FAIL xwin_state: got %b expected %b", q, Q_DONE); end
        checks++; if (cyc > 8) begin errors++; $display("[TB] FAIL xwin_latency: got %0d cycles expected <= 8", cyc); end
        checks++; if (res !== 3'b100) begin errors++; $display("[TB] FAIL xwin_flags: got %b expected 100", res); end
        checks++; if (p1 !== 1 || p2 !== 0) begin errors++; $display("[TB] FAIL xwin_scores: got %0d/%0d expected 1/0", p1, p2); end
        readCell(0, 1, 1, v);
        checks++; if (v !== CELL_O) begin errors++; $display("[TB] FAIL xwin_cell11: got %b expected 10", v); end
        readCell(0, 0, 3, v);
        checks++; if (v !== CELL_EMPTY) begin errors++; $display("[TB] FAIL rd_out_of_range: got %b expected 00", v); end
    endtask

    task automatic test_next_game();
        logic [4:0] q; logic pl; logic [2:0] res; int p1, p2, row, col;
        applyStimulus(0, B_C);
        getStat(0, q, pl, res, p1, p2, row, col);
        checks++; if (q !== Q_STA) begin errors++; $display("[TB] FAIL next_sta: got %b expected %b", q, Q_STA); end
        @(negedge Clk);
        curR[0] = 0; curC[0] = 0;
        getStat(0, q, pl, res, p1, p2, row, col);
        checks++; if (pl !== 1'b1) begin errors++; $display("[TB] FAIL next_first_player: got %b expected 1", pl); end
        checks++; if (p1 !== 1 || res !== 3'b000) begin errors++; $display("[TB] FAIL next_kept: got p1=%0d res=%b expected 1/000", p1, res); end
    endtask

    task automatic test_occupied_and_cursor();
        logic [4:0] q; logic pl; logic [2:0] res; int p1, p2, row, col, cyc; logic [1:0] v;
        mv = '{0,0};
        playMoves(0, cyc);
        applyStimulus(0, B_C | B_R);
        getStat(0, q, pl, res, p1, p2, row, col);
        readCell(0, 0, 0, v);
        checks++; if (v !== CELL_O) begin errors++; $display("[TB] FAIL occupied_cell: got %b expected 10", v); end
        checks++; if (q !== Q_TURN || pl !== 1'b0) begin errors++; $display("[TB] FAIL occupied_turn: got %b/%b expected %b/0", q, pl, Q_TURN); end
        checks++; if (col !== 0) begin errors++; $display("[TB] FAIL btnc_masks_move: got col %0d expected 0", col); end
        applyStimulus(0, B_R);
        applyStimulus(0, B_R);
        getStat(0, q, pl, res, p1, p2, row, col);
        checks++; if (col !== 2) begin errors++; $display("[TB] FAIL right_twice: got col %0d expected 2", col); end
        applyStimulus(0, B_R);
        getStat(0, q, pl, res, p1, p2, row, col);
        checks++; if (col !== 0) begin errors++; $display("[TB] FAIL right_wrap: got col %0d expected 0", col); end
        applyStimulus(0, B_U | B_D);
        getStat(0, q, pl, res, p1, p2, row, col);
        checks++; if (row !== 2) begin errors++; $display("[TB] FAIL up_priority_wrap: got row %0d expected 2", row); end
        applyStimulus(0, B_D);
        applyStimulus(0, B_L);
        getStat(0, q, pl, res, p1, p2, row, col);
        checks++; if (row !== 0 || col !== 2) begin errors++; $display("[TB] FAIL down_left_wrap: got (%0d,%0d) expected (0,2)", row, col); end
        applyStimulus(0, B_R);
        curR[0] = 0; curC[0] = 0;
    endtask

    task automatic test_draw();
        logic [4:0] q; logic pl; logic [2:0] res; int p1, p2, row, col, cyc; logic [1:0] v;
        mv = '{0,1, 0,2, 1,1, 1,0, 1,2, 2,1, 2,0};
        playMoves(0, cyc);
        getStat(0, q, pl, res, p1, p2, row, col);
        checks++; if (q !== Q_TURN || res !== 3'b000) begin errors++; $display("[TB] FAIL before_draw: got %b/%b expected %b/000", q, res, Q_TURN); end
        mv = '{2,2};
        playMoves(0, cyc);
        getStat(0, q, pl, res, p1, p2, row, col);
        checks++; if (q !== Q_DONE || res !== 3'b001) begin errors++; $display("[TB] FAIL draw_result: got %b/%b expected %b/001", q, res, Q_DONE); end
        checks++; if (p1 !== 1 || p2 !== 0) begin errors++; $display("[TB] FAIL draw_scores: got %0d/%0d expected 1/0", p1, p2); end
        readCell(0, 2, 2, v);
        checks++; if (v !== CELL_O) begin errors++; $display("[TB] FAIL draw_last_cell: got %b expected 10", v); end
    endtask

    task automatic test_reset_mid_check();
        logic [4:0] q; logic pl; logic [2:0] res; int p1, p2, row, col; logic [1:0] v; int bad;
        startGame(0, B_C);
        place(0, 1, 1);
        getStat(0, q, pl, res, p1, p2, row, col);
        checks++; if (q !== Q_CHK) begin errors++; $display("[TB] FAIL in_check: got %b expected %b", q, Q_CHK); end
        rst3 = 1'b1;
        #1;
        getStat(0, q, pl, res, p1, p2, row, col);
        checks++; if (q !== Q_INI) begin errors++; $display("[TB] FAIL midreset_state: got %b expected %b", q, Q_INI); end
        checks++; if (p1 !== 0 || p2 !== 0 || res !== 3'b000) begin errors++; $display("[TB] FAIL midreset_score: got %0d/%0d res=%b expected 0/0/000", p1, p2, res); end
        bad = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                readCell(0, r, c, v);
                if (v !== CELL_EMPTY) bad++;
            end
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL midreset_board: got %0d nonempty cells expected 0", bad); end
        @(negedge Clk);
        rst3 = 1'b0;
        curR[0] = 0; curC[0] = 0;
    endtask

    task automatic test_ack_priority();
        logic [4:0] q; logic pl; logic [2:0] res; int p1, p2, row, col, cyc;
        startGame(0, B_ST);
        mv = '{0,0, 1,0, 0,1, 1,1, 0,2};
        playMoves(0, cyc);
        getStat(0, q, pl, res, p1, p2, row, col);
        checks++; if (q !== Q_DONE || p1 !== 1) begin errors++; $display("[TB] FAIL ack_pre: got %b p1=%0d expected %b p1=1", q, p1, Q_DONE); end
        applyStimulus(0, B_AK | B_C);
        getStat(0, q, pl, res, p1, p2, row, col);
        checks++; if (q !== Q_INI) begin errors++; $display("[TB] FAIL ack_wins: got %b expected %b", q, Q_INI); end
        @(negedge Clk);
        getStat(0, q, pl, res, p1, p2, row, col);
        checks++; if (p1 !== 0) begin errors++; $display("[TB] FAIL ack_clears: got p1=%0d expected 0", p1); end
    endtask

    task automatic test_saturate();
        logic [4:0] q; logic pl; logic [2:0] res; int p1, p2, row, col, cyc;
        int expP1[4] = '{1, 2, 3, 3};
        for (int g = 0; g < 4; g++) begin
            startGame(2, (g == 0) ? B_ST : B_C);
            if (g % 2 == 0) mv = '{0,0, 1,0, 0,1, 1,1, 0,2};
            else            mv = '{2,0, 0,0, 2,1, 0,1, 1,1, 0,2};
            playMoves(2, cyc);
            getStat(2, q, pl, res, p1, p2, row, col);
            checks++; if (p1 !== expP1[g] || res !== 3'b100) begin errors++; $display("[TB] FAIL saturate_game%0d: got p1=%0d res=%b expected %0d/100", g, p1, res, expP1[g]); end
        end
    endtask

    task automatic test_anti_diag();
        logic [4:0] q; logic pl; logic [2:0] res; int p1, p2, row, col, cyc; logic [1:0] v;
        startGame(1, B_ST);
        mv = '{4,4, 0,3, 4,2, 1,2, 4,0, 2,1, 3,4, 3,0};
        playMoves(1, cyc);
        getStat(1, q, pl, res, p1, p2, row, col);
        checks++; if (q !== Q_DONE || res !== 3'b010) begin errors++; $display("[TB] FAIL owin_result: got %b/%b expected %b/010", q, res, Q_DONE); end
        checks++; if (p1 !== 0 || p2 !== 1) begin errors++; $display("[TB] FAIL owin_scores: got %0d/%0d expected 0/1", p1, p2); end
        checks++; if (cyc > 24) begin errors++; $display("[TB] FAIL owin_latency: got %0d cycles expected <= 24", cyc); end
        readCell(1, 3, 0, v);
        checks++; if (v !== CELL_O) begin errors++; $display("[TB] FAIL owin_cell30: got %b expected 10", v); end
        readCell(1, 5, 0, v);
        checks++; if (v !== CELL_EMPTY) begin errors++; $display("[TB] FAIL rd_out_of_range_n5: got %b expected 00", v); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst3 = 1'b1; rst5 = 1'b1; rstS = 1'b1;
        for (int s = 0; s < 3; s++) begin
            setIn(s, 7'b0);
            curR[s] = 0;
            curC[s] = 0;
        end
        bus3.RdRow = '0; bus3.RdCol = '0;
        bus5.RdRow = '0; bus5.RdCol = '0;
        busS.RdRow = '0; busS.RdCol = '0;
        repeat (3) @(negedge Clk);
        rst3 = 1'b0; rst5 = 1'b0; rstS = 1'b0;
        @(negedge Clk);

        test_reset();
        test_xwin();
        test_next_game();
        test_occupied_and_cursor();
        test_draw();
        test_reset_mid_check();
        test_ack_priority();
        test_saturate();
        test_anti_diag();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
